tap_scan_engine: RTL

Complete single-clock test-access block: IEEE 1149.1-style 16-state TAP controller driven by tms, a parametrised instruction register with shadow, NUM_CHAINS user scan chains of CHAIN_WIDTH bits each with capture and update shadows, a 1-bit bypass register and a 32-bit IDCODE register. Generalises the existing fixed-width scan_block/ir_scan_path/bypass pieces into one instruction-selected engine. Sits at the chip test port; clk is used directly as TCK.

---
 rtl/tap_scan_pkg.sv | 35 +++
 rtl/tap_fsm.sv | 56 +++++
 rtl/tap_scan_engine.sv | 130 +++++++++++++
 3 files changed

// File: rtl/tap_scan_pkg.sv
// Shared definitions for the test-access engine: TAP state encodings
// and the opcode and capture constants derived from the IR width.
package tap_scan_pkg;

  // Encoding matches the IEEE 1149.1 reference state assignment.
  typedef enum logic [3:0] {
    EXIT2_DR         = 4'h0,
    EXIT1_DR         = 4'h1,
    SHIFT_DR         = 4'h2,
    PAUSE_DR         = 4'h3,
    SELECT_IR        = 4'h4,
    UPDATE_DR        = 4'h5,
    CAPTURE_DR       = 4'h6,
    SELECT_DR        = 4'h7,
    EXIT2_IR         = 4'h8,
    EXIT1_IR         = 4'h9,
    SHIFT_IR         = 4'hA,
    PAUSE_IR         = 4'hB,
    RUN_TEST_IDLE    = 4'hC,
    UPDATE_IR        = 4'hD,
    CAPTURE_IR       = 4'hE,
    TEST_LOGIC_RESET = 4'hF
  } tap_state_e;

  localparam logic [1:0] IR_CAPTURE = 2'b01;

  function automatic int unsigned idcode_op(input int unsigned ir_width);
    return (32'd1 << ir_width) - 32'd2;
  endfunction

  function automatic int unsigned bypass_op(input int unsigned ir_width);
    return (32'd1 << ir_width) - 32'd1;
  endfunction

endpackage

// File: rtl/tap_fsm.sv
// 16-state TAP controller stepped by tms on every TCK rising edge, with
// one-hot decodes telling the datapath what the coming edge does.
module tap_fsm
  import tap_scan_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       tms,
  output tap_state_e state,
  output logic       tlr,
  output logic       capture_ir,
  output logic       shift_ir,
  output logic       update_ir,
  output logic       capture_dr,
  output logic       shift_dr,
  output logic       update_dr
);

  tap_state_e r_state;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= TEST_LOGIC_RESET;
    end else begin
      case (r_state)
        TEST_LOGIC_RESET: r_state <= tms ? TEST_LOGIC_RESET : RUN_TEST_IDLE;
        RUN_TEST_IDLE:    r_state <= tms ? SELECT_DR : RUN_TEST_IDLE;
        SELECT_DR:        r_state <= tms ? SELECT_IR : CAPTURE_DR;
        CAPTURE_DR:       r_state <= tms ? EXIT1_DR : SHIFT_DR;
        SHIFT_DR:         r_state <= tms ? EXIT1_DR : SHIFT_DR;
        EXIT1_DR:         r_state <= tms ? UPDATE_DR : PAUSE_DR;
        PAUSE_DR:         r_state <= tms ? EXIT2_DR : PAUSE_DR;
        EXIT2_DR:         r_state <= tms ? UPDATE_DR : SHIFT_DR;
        UPDATE_DR:        r_state <= tms ? SELECT_DR : RUN_TEST_IDLE;
        SELECT_IR:        r_state <= tms ? TEST_LOGIC_RESET : CAPTURE_IR;
        CAPTURE_IR:       r_state <= tms ? EXIT1_IR : SHIFT_IR;
        SHIFT_IR:         r_state <= tms ? EXIT1_IR : SHIFT_IR;
        EXIT1_IR:         r_state <= tms ? UPDATE_IR : PAUSE_IR;
        PAUSE_IR:         r_state <= tms ? EXIT2_IR : PAUSE_IR;
        EXIT2_IR:         r_state <= tms ? UPDATE_IR : SHIFT_IR;
        UPDATE_IR:        r_state <= tms ? SELECT_DR : RUN_TEST_IDLE;
        default:          r_state <= TEST_LOGIC_RESET;
      endcase
    end
  end

  assign state      = r_state;
  assign tlr        = (r_state == TEST_LOGIC_RESET);
  assign capture_ir = (r_state == CAPTURE_IR);
  assign shift_ir   = (r_state == SHIFT_IR);
  assign update_ir  = (r_state == UPDATE_IR);
  assign capture_dr = (r_state == CAPTURE_DR);
  assign shift_dr   = (r_state == SHIFT_DR);
  assign update_dr  = (r_state == UPDATE_DR);

endmodule

// File: rtl/tap_scan_engine.sv
// Instruction-selected scan engine: IR with shadow, user chains with
// capture/update shadows, bypass and IDCODE, all clocked directly by TCK.
module tap_scan_engine
  import tap_scan_pkg::*;
#(
  parameter int          IR_WIDTH    = 4,
  parameter int          NUM_CHAINS  = 2,
  parameter int          CHAIN_WIDTH = 8,
  parameter logic [31:0] IDCODE_VAL  = 32'h1000_0001
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              tms,
  input  logic                              tdi,
  output logic                              tdo,
  output logic                              tdo_en,
  input  logic [NUM_CHAINS*CHAIN_WIDTH-1:0] capture_data,
  output logic [NUM_CHAINS*CHAIN_WIDTH-1:0] update_data,
  output logic [NUM_CHAINS-1:0]             update_strobe,
  output logic [IR_WIDTH-1:0]               instruction,
  output logic [3:0]                        tap_state
);

  localparam logic [IR_WIDTH-1:0] IDCODE_OP = IR_WIDTH'(idcode_op(IR_WIDTH));
  localparam logic [IR_WIDTH-1:0] BYPASS_OP = IR_WIDTH'(bypass_op(IR_WIDTH));

  tap_state_e w_state;
  logic w_tlr, w_capture_ir, w_shift_ir, w_update_ir;
  logic w_capture_dr, w_shift_dr, w_update_dr;
  logic [NUM_CHAINS-1:0] w_sel_chain;
  logic [NUM_CHAINS-1:0] w_chain_msb;
  logic w_sel_idcode, w_sel_bypass;

  logic [IR_WIDTH-1:0] r_ir;
  logic [IR_WIDTH-1:0] r_instruction;
  logic [31:0]         r_idcode;
  logic                r_bypass;

  tap_fsm u_fsm (
    .clk        (clk),
    .reset      (reset),
    .tms        (tms),
    .state      (w_state),
    .tlr        (w_tlr),
    .capture_ir (w_capture_ir),
    .shift_ir   (w_shift_ir),
    .update_ir  (w_update_ir),
    .capture_dr (w_capture_dr),
    .shift_dr   (w_shift_dr),
    .update_dr  (w_update_dr)
  );

  // Anything that is neither a chain index nor IDCODE falls back to bypass.
  assign w_sel_idcode = (r_instruction == IDCODE_OP);
  assign w_sel_bypass = (r_instruction == BYPASS_OP) | ~(|w_sel_chain | w_sel_idcode);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_ir          <= '0;
      r_instruction <= IDCODE_OP;
      r_idcode      <= '0;
      r_bypass      <= 1'b0;
    end else begin
      if (w_capture_ir)    r_ir <= IR_WIDTH'(IR_CAPTURE);
      else if (w_shift_ir) r_ir <= {r_ir[IR_WIDTH-2:0], tdi};

      if (w_tlr)            r_instruction <= IDCODE_OP;
      else if (w_update_ir) r_instruction <= r_ir;

      if (w_sel_idcode) begin
        if (w_capture_dr)    r_idcode <= IDCODE_VAL;
        else if (w_shift_dr) r_idcode <= {r_idcode[30:0], tdi};
      end

      if (w_sel_bypass) begin
        if (w_capture_dr)    r_bypass <= 1'b0;
        else if (w_shift_dr) r_bypass <= tdi;
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CHAINS; gi++) begin : g_chain
      logic [CHAIN_WIDTH-1:0] r_shift;
      logic [CHAIN_WIDTH-1:0] r_shadow;
      logic                   r_strobe;

      assign w_sel_chain[gi] = (r_instruction == IR_WIDTH'(gi));

      always_ff @(posedge clk) begin
        if (reset) begin
          r_shift  <= '0;
          r_shadow <= '0;
          r_strobe <= 1'b0;
        end else begin
          r_strobe <= 1'b0;
          if (w_sel_chain[gi]) begin
            if (w_capture_dr)    r_shift <= capture_data[gi*CHAIN_WIDTH +: CHAIN_WIDTH];
            else if (w_shift_dr) r_shift <= (r_shift << 1) | CHAIN_WIDTH'(tdi);
            if (w_update_dr) begin
              r_shadow <= r_shift;
              r_strobe <= 1'b1;
            end
          end
        end
      end

      assign w_chain_msb[gi]                                = r_shift[CHAIN_WIDTH-1];
      assign update_data[gi*CHAIN_WIDTH +: CHAIN_WIDTH]     = r_shadow;
      assign update_strobe[gi]                              = r_strobe;
    end
  endgenerate

  always_comb begin
    tdo = 1'b0;
    if (w_shift_ir) begin
      tdo = r_ir[IR_WIDTH-1];
    end else if (w_shift_dr) begin
      if (w_sel_idcode)      tdo = r_idcode[31];
      else if (w_sel_bypass) tdo = r_bypass;
      else                   tdo = |(w_chain_msb & w_sel_chain);
    end
  end

  assign tdo_en      = w_shift_ir | w_shift_dr;
  assign instruction = r_instruction;
  assign tap_state   = w_state;

endmodule
